ripple_count_capture: RTL and testbench

Synchronous snapshot stage downstream of the N-bit asynchronous ripple up-counter built from toggle flip-flops. The ripple counter's bits settle one flop delay apart and run in an unrelated timing domain, so a direct sample can return a transient value. On request, this block synchronises the counter bus and re-samples it until two consecutive samples agree, or until a retry limit is reached. It then presents the settled count, plus the modular delta since the previous accepted capture, on a valid/ready interface.

---
 rtl/ripple_count_capture_pkg.sv | 18 +
 rtl/sync_2ff.sv | 21 ++
 rtl/ripple_count_capture.sv | 99 +++++++++
 tb/tb_ripple_count_capture.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ripple_count_capture_pkg.sv
// Shared types and constants for the ripple-counter snapshot stage.
// Sizing helpers live here so the top and any future siblings agree on widths.
package ripple_count_capture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int SYNC_STAGES = 2;

  function automatic int try_width(input int max_tries);
    return $clog2(max_tries);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser for bringing a ripple-counter bit into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ripple_count_capture.sv
// Snapshot stage for an asynchronous ripple counter: synchronise, re-sample until two
// consecutive samples agree (or the retry limit hits), then hand off count and delta.
module ripple_count_capture
  import ripple_count_capture_pkg::*;
#(
  parameter int N         = 8,
  parameter int MAX_TRIES = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] cnt_in,
  input  logic         req,
  output logic         busy,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] data,
  output logic [N-1:0] delta,
  output logic         timeout
);

  localparam int TW = try_width(MAX_TRIES);
  localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
  localparam logic [1:0] SYNC_LAST = 2'(SYNC_STAGES);

  state_t        state;
  logic [N-1:0]  sync_q;
  logic [N-1:0]  s_prev;
  logic [N-1:0]  last_count;
  logic [TW-1:0] try_cnt;
  logic [1:0]    sync_wait;

  for (genvar i = 0; i < N; i++) begin : g_sync
    sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (cnt_in[i]),
      .q     (sync_q[i])
    );
  end

  // SYNC dwells until the synchroniser holds only post-request samples, then SAMPLE
  // keeps comparing against the previous sample until the bus has settled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      valid      <= 1'b0;
      data       <= '0;
      delta      <= '0;
      timeout    <= 1'b0;
      last_count <= '0;
      s_prev     <= '0;
      try_cnt    <= '0;
      sync_wait  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state     <= SYNC;
            busy      <= 1'b1;
            sync_wait <= '0;
            try_cnt   <= '0;
          end
        end
        SYNC: begin
          if (sync_wait == SYNC_LAST) begin
            s_prev <= sync_q;
            state  <= SAMPLE;
          end else begin
            sync_wait <= sync_wait + 2'd1;
          end
        end
        SAMPLE: begin
          if (sync_q == s_prev || try_cnt == TRY_LAST) begin
            data    <= sync_q;
            delta   <= sync_q - last_count;
            timeout <= (sync_q != s_prev);
            valid   <= 1'b1;
            state   <= DONE;
          end else begin
            s_prev  <= sync_q;
            try_cnt <= try_cnt + 1'b1;
          end
        end
        DONE: begin
          // last_count only advances on acceptance so delta tracks consumed results
          if (ready) begin
            last_count <= data;
            valid      <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed bench for ripple_count_capture: default instance for most scenarios,
// a MAX_TRIES=4 instance for the forced-completion path.
module tb_ripple_count_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cnt_in;
  logic       req;
  logic       ready;
  logic       busy;
  logic       valid;
  logic [7:0] data;
  logic [7:0] delta;
  logic       timeout;

  logic [7:0] cnt_in2;
  logic       req2;
  logic       ready2;
  logic       busy2;
  logic       valid2;
  logic [7:0] data2;
  logic [7:0] delta2;
  logic       timeout2;

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  ripple_count_capture #(.N(8), .MAX_TRIES(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .cnt_in  (cnt_in),
    .req     (req),
    .busy    (busy),
    .valid   (valid),
    .ready   (ready),
    .data    (data),
    .delta   (delta),
    .timeout (timeout)
  );

  ripple_count_capture #(.N(8), .MAX_TRIES(4)) dut_short (
    .clk     (clk),
    .reset   (reset),
    .cnt_in  (cnt_in2),
    .req     (req2),
    .busy    (busy2),
    .valid   (valid2),
    .ready   (ready2),
    .data    (data2),
    .delta   (delta2),
    .timeout (timeout2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the default instance's inputs so they are seen by the next rising edge.
  task automatic applyStimulus(input logic r, input logic [7:0] c, input logic rd);
    req    = r;
    cnt_in = c;
    ready  = rd;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic checkCleared(input string tag);
    checkFlag({tag, ".busy"}, busy, 1'b0);
    checkFlag({tag, ".valid"}, valid, 1'b0);
    checkOutput({tag, ".data"}, data, 8'h00);
    checkOutput({tag, ".delta"}, delta, 8'h00);
    checkFlag({tag, ".timeout"}, timeout, 1'b0);
  endtask

  logic [7:0] ripple_seq [9];

  initial begin
    ripple_seq = '{8'h7F, 8'h7E, 8'h7C, 8'h78, 8'h70, 8'h60, 8'h40, 8'h00, 8'h80};
    reset = 1'b1; req = 1'b0; ready = 1'b1; cnt_in = 8'h2A;
    req2 = 1'b0; ready2 = 1'b1; cnt_in2 = 8'h00;
    tick();
    tick();
    $display("[TB] reset state");
    checkCleared("reset");
    reset = 1'b0;
    applyStimulus(1'b0, 8'h2A, 1'b1);
    applyStimulus(1'b0, 8'h2A, 1'b1);

    $display("[TB] stable capture");
    applyStimulus(1'b1, 8'h2A, 1'b1);
    checkFlag("stable.busy_k", busy, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h2A, 1'b1);
    checkFlag("stable.valid_k3", valid, 1'b0);
    applyStimulus(1'b0, 8'h2A, 1'b1);
    checkFlag("stable.valid_k4", valid, 1'b1);
    checkOutput("stable.data", data, 8'h2A);
    checkOutput("stable.delta", delta, 8'h2A);
    checkFlag("stable.timeout", timeout, 1'b0);
    applyStimulus(1'b0, 8'h2A, 1'b1);
    checkFlag("stable.valid_acc", valid, 1'b0);
    checkFlag("stable.busy_acc", busy, 1'b0);

    $display("[TB] wrap-around delta");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h05, 1'b1);
    applyStimulus(1'b1, 8'h05, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h05, 1'b1);
    checkFlag("wrap.valid", valid, 1'b1);
    checkOutput("wrap.data", data, 8'h05);
    checkOutput("wrap.delta", delta, 8'hDB);
    applyStimulus(1'b0, 8'h05, 1'b1);

    $display("[TB] ripple transient");
    applyStimulus(1'b1, ripple_seq[0], 1'b1);
    for (int j = 1; j < 9; j++) applyStimulus(1'b0, ripple_seq[j], 1'b1);
    applyStimulus(1'b0, 8'h80, 1'b1);
    applyStimulus(1'b0, 8'h80, 1'b1);
    checkFlag("ripple.valid_k10", valid, 1'b0);
    applyStimulus(1'b0, 8'h80, 1'b1);
    checkFlag("ripple.valid_k11", valid, 1'b1);
    checkOutput("ripple.data", data, 8'h80);
    checkOutput("ripple.delta", delta, 8'h7B);
    checkFlag("ripple.timeout", timeout, 1'b0);
    applyStimulus(1'b0, 8'h80, 1'b1);

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h44, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h44, 1'b0);
    checkFlag("bp.valid", valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i[0], 8'h99, 1'b0);
      checkFlag("bp.valid_hold", valid, 1'b1);
      checkFlag("bp.busy_hold", busy, 1'b1);
      checkOutput("bp.data_hold", data, 8'h44);
      checkOutput("bp.delta_hold", delta, 8'hC4);
      checkFlag("bp.timeout_hold", timeout, 1'b0);
    end
    applyStimulus(1'b0, 8'h99, 1'b1);
    checkFlag("bp.valid_drop", valid, 1'b0);
    checkFlag("bp.busy_drop", busy, 1'b0);
    applyStimulus(1'b0, 8'h99, 1'b1);
    checkFlag("bp.no_extra", busy, 1'b0);

    $display("[TB] reset during SAMPLE");
    applyStimulus(1'b1, 8'h99, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h99, 1'b1);
    checkFlag("rsts.busy_pre", busy, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b0, 8'h99, 1'b1);
    checkCleared("rst_sample");
    reset = 1'b0;

    $display("[TB] reset during DONE");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h55, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h55, 1'b0);
    checkFlag("rstd.valid_pre", valid, 1'b1);
    checkOutput("rstd.data_pre", data, 8'h55);
    reset = 1'b1;
    applyStimulus(1'b0, 8'h55, 1'b0);
    checkCleared("rst_done");
    reset = 1'b0;

    $display("[TB] capture after reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h33, 1'b1);
    applyStimulus(1'b1, 8'h33, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h33, 1'b1);
    checkFlag("post.valid", valid, 1'b1);
    checkOutput("post.data", data, 8'h33);
    checkOutput("post.delta", delta, 8'h33);
    applyStimulus(1'b0, 8'h33, 1'b1);

    $display("[TB] retry limit (MAX_TRIES=4)");
    cnt_in2 = 8'h10;
    req2    = 1'b1;
    tick();
    req2 = 1'b0;
    for (int j = 1; j < 7; j++) begin
      cnt_in2 = 8'h10 + 8'(j);
      tick();
    end
    checkFlag("retry.valid_k6", valid2, 1'b0);
    cnt_in2 = 8'h17;
    tick();
    checkFlag("retry.valid_k7", valid2, 1'b1);
    checkFlag("retry.timeout", timeout2, 1'b1);
    checkOutput("retry.data", data2, 8'h15);
    checkOutput("retry.delta", delta2, 8'h15);
    tick();
    checkFlag("retry.valid_acc", valid2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
